// File: rtl/biquad_uart_pkg.sv
// biquad_uart_pkg
//   Shared definitions for the biquad UART command controller:
//   - ASCII command keywords as they appear in the 32-bit keyword shift register
//   - RX state encoding (also driven out on the 'state' port)
//   - coefficient index encoding within one biquad section
package biquad_uart_pkg;

  // Keywords, first received character in the most significant byte
  localparam logic [31:0] KW_COEF = 32'h636F6566;  // "coef"
  localparam logic [31:0] KW_DATA = 32'h64617461;  // "data"
  localparam logic [31:0] KW_DONE = 32'h646F6E65;  // "done"

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COEF = 2'd1,
    ST_LEN  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CI_B0 = 3'd0,
    CI_B1 = 3'd1,
    CI_B2 = 3'd2,
    CI_Q  = 3'd3,
    CI_A1 = 3'd4,
    CI_A2 = 3'd5
  } coef_idx_t;

endpackage

// File: rtl/biquad_tx_ser.sv
// biquad_tx_ser
//   Holds one filter output word and pushes it to the UART TX FIFO one byte
//   per cycle, most significant byte first. tx_full pauses the push without
//   losing or reordering bytes. A new word is accepted only once the previous
//   one has been fully pushed.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   y_valid, y_data   filter output word
//   y_ready           high while the holding register is empty
//   tx_full           TX FIFO full
//   wr_uart, w_data   TX push strobe and byte
module biquad_tx_ser #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          y_valid,
  input  logic [DW-1:0] y_data,
  output logic          y_ready,
  input  logic          tx_full,
  output logic          wr_uart,
  output logic [7:0]    w_data
);

  localparam int BPW = DW / 8;

  logic [DW-1:0] hold_q;
  logic [2:0]    pend_q;

  // y_ready is forced low during reset so every output reads 0 while reset is held
  assign y_ready = ~reset & (pend_q == 3'd0);
  assign wr_uart = (pend_q != 3'd0) & ~tx_full;
  assign w_data  = hold_q[DW-1 -: 8];

  // The word is shifted left after each push so the next byte is always on top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      pend_q <= '0;
    end else if (y_valid && y_ready) begin
      hold_q <= y_data;
      pend_q <= 3'(BPW);
    end else if (wr_uart) begin
      hold_q <= hold_q << 8;
      pend_q <= pend_q - 3'd1;
    end
  end

endmodule

// File: rtl/biquad_uart_ctrl.sv
// biquad_uart_ctrl
//   Byte-stream command controller between the UART FIFOs and a multi-section
//   biquad core. ASCII commands "coef", "data" and "done" are recognised in
//   IDLE; "coef" loads 6*NSEC coefficient words, "data" takes a 16-bit sample
//   count followed by that many samples, "done" pulses filt_clr. Filter outputs
//   are serialised back to the UART TX FIFO by biquad_tx_ser.
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   rx_empty, r_data, rd_uart      UART RX FIFO head and pop
//   tx_full, wr_uart, w_data       UART TX FIFO push
//   coef_we, coef_sec, coef_idx,
//   coef_data                      coefficient write port
//   filt_clr                       clear filter state and coefficients
//   x_valid, x_data, x_ready       input sample handshake
//   y_valid, y_data, y_ready       output sample handshake
//   state                          0=IDLE 1=COEF 2=LEN 3=DATA
module biquad_uart_ctrl
  import biquad_uart_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NSEC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_empty,
  input  logic [7:0]    r_data,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic          wr_uart,
  output logic [7:0]    w_data,
  output logic          coef_we,
  output logic [2:0]    coef_sec,
  output logic [2:0]    coef_idx,
  output logic [DW-1:0] coef_data,
  output logic          filt_clr,
  output logic          x_valid,
  output logic [DW-1:0] x_data,
  input  logic          x_ready,
  input  logic          y_valid,
  input  logic [DW-1:0] y_data,
  output logic          y_ready,
  output logic [1:0]    state
);

  localparam int         BPW       = DW / 8;
  localparam logic [2:0] BYTE_LAST = 3'(BPW - 1);
  localparam logic [2:0] SEC_LAST  = 3'(NSEC - 1);

  state_t        cur_state, nxt_state;
  logic [31:0]   kw_q, kw_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [DW-1:0] word_q, word_d;
  logic [2:0]    sec_q, sec_d;
  coef_idx_t     idx_q, idx_d;
  logic [15:0]   remain_q, remain_d;

  logic          coef_we_q, coef_we_d;
  logic [2:0]    coef_sec_q, coef_sec_d;
  coef_idx_t     coef_idx_q, coef_idx_d;
  logic [DW-1:0] coef_data_q, coef_data_d;
  logic          filt_clr_q, filt_clr_d;
  logic          x_valid_q, x_valid_d;
  logic [DW-1:0] x_data_q, x_data_d;

  logic          stall, pop, x_xfer;
  logic [31:0]   kw_shift;
  logic [DW-1:0] word_shift;
  logic [15:0]   len_shift;

  // Only a held, unaccepted sample can block the RX side
  assign stall   = ((cur_state == ST_DATA) || (cur_state == ST_LEN)) & x_valid_q & ~x_ready;
  assign pop     = ~reset & ~rx_empty & ~stall;
  assign rd_uart = pop;
  assign x_xfer  = x_valid_q & x_ready;

  assign kw_shift   = 32'({kw_q, r_data});
  assign word_shift = DW'({word_q, r_data});
  assign len_shift  = {remain_q[7:0], r_data};

  always_comb begin
    nxt_state   = cur_state;
    kw_d        = kw_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    sec_d       = sec_q;
    idx_d       = idx_q;
    remain_d    = remain_q;
    coef_we_d   = 1'b0;
    coef_sec_d  = coef_sec_q;
    coef_idx_d  = coef_idx_q;
    coef_data_d = coef_data_q;
    filt_clr_d  = 1'b0;
    x_valid_d   = x_valid_q & ~x_ready;
    x_data_d    = x_data_q;

    case (cur_state)
      ST_IDLE: begin
        if (pop) begin
          kw_d = kw_shift;
          // Clearing on a match stops a trailing fragment from matching again
          if (kw_shift == KW_COEF) begin
            kw_d       = '0;
            byte_cnt_d = '0;
            sec_d      = '0;
            idx_d      = CI_B0;
            nxt_state  = ST_COEF;
          end else if (kw_shift == KW_DATA) begin
            kw_d       = '0;
            byte_cnt_d = '0;
            nxt_state  = ST_LEN;
          end else if (kw_shift == KW_DONE) begin
            kw_d       = '0;
            filt_clr_d = 1'b1;
          end
        end
      end

      ST_COEF: begin
        if (pop) begin
          word_d = word_shift;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d  = '0;
            coef_we_d   = 1'b1;
            coef_data_d = word_shift;
            coef_sec_d  = sec_q;
            coef_idx_d  = idx_q;
            if (idx_q == CI_A2) begin
              idx_d = CI_B0;
              if (sec_q == SEC_LAST) begin
                sec_d     = '0;
                nxt_state = ST_IDLE;
              end else begin
                sec_d = sec_q + 3'd1;
              end
            end else begin
              idx_d = coef_idx_t'(idx_q + 3'd1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end

      ST_LEN: begin
        if (pop) begin
          if (byte_cnt_q == 3'd0) begin
            remain_d   = {8'h00, r_data};
            byte_cnt_d = 3'd1;
          end else begin
            remain_d   = len_shift;
            byte_cnt_d = '0;
            nxt_state  = (len_shift == 16'h0000) ? ST_IDLE : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (x_xfer) begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) nxt_state = ST_IDLE;
        end
        if (pop) begin
          // A byte popped alongside the final transfer already belongs to the next command
          if (x_xfer && (remain_q == 16'd1)) begin
            kw_d = kw_shift;
          end else begin
            word_d = word_shift;
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d = '0;
              x_valid_d  = 1'b1;
              x_data_d   = word_shift;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
      end

      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      kw_q        <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      sec_q       <= '0;
      idx_q       <= CI_B0;
      remain_q    <= '0;
      coef_we_q   <= 1'b0;
      coef_sec_q  <= '0;
      coef_idx_q  <= CI_B0;
      coef_data_q <= '0;
      filt_clr_q  <= 1'b0;
      x_valid_q   <= 1'b0;
      x_data_q    <= '0;
    end else begin
      cur_state   <= nxt_state;
      kw_q        <= kw_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      sec_q       <= sec_d;
      idx_q       <= idx_d;
      remain_q    <= remain_d;
      coef_we_q   <= coef_we_d;
      coef_sec_q  <= coef_sec_d;
      coef_idx_q  <= coef_idx_d;
      coef_data_q <= coef_data_d;
      filt_clr_q  <= filt_clr_d;
      x_valid_q   <= x_valid_d;
      x_data_q    <= x_data_d;
    end
  end

  assign coef_we   = coef_we_q;
  assign coef_sec  = coef_sec_q;
  assign coef_idx  = coef_idx_q;
  assign coef_data = coef_data_q;
  assign filt_clr  = filt_clr_q;
  assign x_valid   = x_valid_q;
  assign x_data    = x_data_q;
  assign state     = cur_state;

  biquad_tx_ser #(.DW(DW)) u_tx_ser (
    .clk     (clk),
    .reset   (reset),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .tx_full (tx_full),
    .wr_uart (wr_uart),
    .w_data  (w_data)
  );

endmodule
